// File: rtl/variable_pkg.sv
// Shared game constants, player encodings and the turn/throw state type.
package variable_pkg;

    localparam int unsigned POS_W    = 12;
    localparam int unsigned POWER_W  = 6;
    localparam int unsigned TICK_W   = 20;
    localparam int unsigned FLIGHT_W = 28;
    localparam int unsigned LOCK_W   = 25;

    localparam logic [1:0] NOBODY   = 2'b00;
    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;

    localparam int unsigned P1_X_MIN  = 40;
    localparam int unsigned P1_X_MAX  = 140;
    localparam int unsigned P2_X_MIN  = 884;
    localparam int unsigned P2_X_MAX  = 984;
    localparam int unsigned TGT_Y_MIN = 660;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        CHARGE,
        FLIGHT,
        LANDED
    } throw_state_t;

endpackage

// File: rtl/btn_edge.sv
// Registers the fire button and flags its rising and falling edges.
module btn_edge (
    input  logic clk60MHz,
    input  logic rst,
    input  logic btn,
    output logic press_c,
    output logic release_c
);

    logic btn_q;
    logic btn_prev;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            btn_q    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_q    <= btn;
            btn_prev <= btn_q;
        end
    end

    assign press_c   = btn_q & ~btn_prev;
    assign release_c = ~btn_q & btn_prev;

endmodule

// File: rtl/throw_ctrl.sv
// Turn and throw sequencer: charges power, times the flight, detects the end and swaps turns.
module throw_ctrl
    import variable_pkg::*;
#(
    parameter int unsigned GROUND_Y     = 768,
    parameter int unsigned SCREEN_W     = 1024,
    parameter int unsigned POWER_TICK   = 600000,
    parameter int unsigned ARM_DELAY    = 4,
    parameter int unsigned MAX_FLIGHT   = 180000000,
    parameter int unsigned SWITCH_DELAY = 30000000
) (
    input  logic               clk60MHz,
    input  logic               rst,
    input  logic               start_game,
    input  logic               fire_btn,
    input  logic [POS_W-1:0]   xpos_prebuff,
    input  logic [POS_W-1:0]   ypos_prebuff,
    output logic [1:0]         current_player,
    output logic [POWER_W-1:0] power,
    output logic               throw_flag,
    output logic               in_throw_flag,
    output logic               end_throw,
    output logic               hit_p1,
    output logic               hit_p2
);

    throw_state_t        state_q, state_nxt;
    logic [TICK_W-1:0]   tick_q, tick_nxt;
    logic [FLIGHT_W-1:0] flight_q, flight_nxt;
    logic [LOCK_W-1:0]   lock_q, lock_nxt;
    logic [1:0]          player_nxt;
    logic [POWER_W-1:0]  power_nxt;
    logic                throw_flag_nxt, in_throw_nxt, end_throw_nxt, hit_p1_nxt, hit_p2_nxt;

    logic               press_c, release_c;
    logic [POS_W-1:0]   tgt_min_c, tgt_max_c;
    logic               armed_c, hit_c, miss_c, timeout_c, end_c, lock_done_c;

    btn_edge u_btn_edge (
        .clk60MHz  (clk60MHz),
        .rst       (rst),
        .btn       (fire_btn),
        .press_c   (press_c),
        .release_c (release_c)
    );

    // The thrower aims at the opponent's box.
    assign tgt_min_c = (current_player == PLAYER_1) ? POS_W'(P2_X_MIN) : POS_W'(P1_X_MIN);
    assign tgt_max_c = (current_player == PLAYER_1) ? POS_W'(P2_X_MAX) : POS_W'(P1_X_MAX);

    assign armed_c     = flight_q >= FLIGHT_W'(ARM_DELAY);
    assign hit_c       = armed_c && (xpos_prebuff >= tgt_min_c) && (xpos_prebuff <= tgt_max_c)
                         && (ypos_prebuff >= POS_W'(TGT_Y_MIN));
    assign miss_c      = armed_c && ((ypos_prebuff >= POS_W'(GROUND_Y))
                         || (xpos_prebuff >= POS_W'(SCREEN_W)));
    assign timeout_c   = flight_q == FLIGHT_W'(MAX_FLIGHT - 1);
    assign end_c       = hit_c || miss_c || timeout_c;
    assign lock_done_c = lock_q == LOCK_W'(SWITCH_DELAY - 1);

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            flight_q       <= '0;
            lock_q         <= '0;
            current_player <= NOBODY;
            power          <= '0;
            throw_flag     <= 1'b0;
            in_throw_flag  <= 1'b0;
            end_throw      <= 1'b0;
            hit_p1         <= 1'b0;
            hit_p2         <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            tick_q         <= tick_nxt;
            flight_q       <= flight_nxt;
            lock_q         <= lock_nxt;
            current_player <= player_nxt;
            power          <= power_nxt;
            throw_flag     <= throw_flag_nxt;
            in_throw_flag  <= in_throw_nxt;
            end_throw      <= end_throw_nxt;
            hit_p1         <= hit_p1_nxt;
            hit_p2         <= hit_p2_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start_game)  state_nxt = AIM;
            AIM:     if (press_c)     state_nxt = CHARGE;
            CHARGE:  if (release_c)   state_nxt = FLIGHT;
            FLIGHT:  if (end_c)       state_nxt = LANDED;
            LANDED:  if (lock_done_c) state_nxt = AIM;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters; pulses default low.
    always_comb begin
        tick_nxt       = tick_q;
        flight_nxt     = flight_q;
        lock_nxt       = lock_q;
        player_nxt     = current_player;
        power_nxt      = power;
        throw_flag_nxt = 1'b0;
        in_throw_nxt   = in_throw_flag;
        end_throw_nxt  = 1'b0;
        hit_p1_nxt     = 1'b0;
        hit_p2_nxt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_game) player_nxt = PLAYER_1;
            end
            AIM: begin
                if (press_c) begin
                    power_nxt = POWER_W'(1);
                    tick_nxt  = '0;
                end
            end
            CHARGE: begin
                if (release_c) begin
                    throw_flag_nxt = 1'b1;
                    in_throw_nxt   = 1'b1;
                    flight_nxt     = '0;
                end else if (tick_q == TICK_W'(POWER_TICK - 1)) begin
                    tick_nxt = '0;
                    if (power != '1) power_nxt = power + POWER_W'(1);
                end else begin
                    tick_nxt = tick_q + TICK_W'(1);
                end
            end
            FLIGHT: begin
                if (end_c) begin
                    end_throw_nxt = 1'b1;
                    in_throw_nxt  = 1'b0;
                    hit_p1_nxt    = hit_c && (current_player == PLAYER_2);
                    hit_p2_nxt    = hit_c && (current_player == PLAYER_1);
                    lock_nxt      = '0;
                end else begin
                    flight_nxt = flight_q + FLIGHT_W'(1);
                end
            end
            LANDED: begin
                if (lock_done_c) begin
                    player_nxt = (current_player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                end else begin
                    lock_nxt = lock_q + LOCK_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_throw_ctrl.sv
// Randomised bench for throw_ctrl checked against a per-throw outcome model.
module tb_throw_ctrl;

    localparam int PT = 10;
    localparam int AD = 4;
    localparam int MF = 60;
    localparam int SD = 8;

    logic        clk60MHz = 1'b0;
    logic        rst, start_game, fire_btn;
    logic [11:0] xpos_prebuff, ypos_prebuff;
    logic [1:0]  current_player;
    logic [5:0]  power;
    logic        throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  m_player;
    int          px[MF];
    int          py[MF];

    throw_ctrl #(
        .GROUND_Y(768), .SCREEN_W(1024), .POWER_TICK(PT), .ARM_DELAY(AD),
        .MAX_FLIGHT(MF), .SWITCH_DELAY(SD)
    ) dut (
        .clk60MHz(clk60MHz), .rst(rst), .start_game(start_game), .fire_btn(fire_btn),
        .xpos_prebuff(xpos_prebuff), .ypos_prebuff(ypos_prebuff),
        .current_player(current_player), .power(power), .throw_flag(throw_flag),
        .in_throw_flag(in_throw_flag), .end_throw(end_throw), .hit_p1(hit_p1), .hit_p2(hit_p2)
    );

    always #8 clk60MHz = ~clk60MHz;

    task automatic step;
        @(posedge clk60MHz);
        #1;
    endtask

    function automatic int box_min(input logic [1:0] p);
        return (p == 2'b01) ? 884 : 40;
    endfunction

    function automatic int box_max(input logic [1:0] p);
        return (p == 2'b01) ? 984 : 140;
    endfunction

    function automatic int own_min(input logic [1:0] p);
        return (p == 2'b01) ? 40 : 884;
    endfunction

    // Per-flight-cycle positions: 0 directed hit, 1 hit+ground, 2 ground miss, 3 timeout, 4 random.
    task automatic fill_flight(input int mode);
        int k_evt, sel;
        k_evt = $urandom_range(AD - 2, MF + 5);
        for (int k = 0; k < MF; k++) begin
            px[k] = $urandom_range(0, 1023);
            py[k] = (k < AD) ? 768 : $urandom_range(0, 659);
            case (mode)
                0: begin px[k] = (k < 3) ? 500 : box_min(m_player) + 16; py[k] = (k < 3) ? 768 : 700; end
                1: begin px[k] = box_min(m_player) + 16; py[k] = 768; end
                2: begin px[k] = 500; py[k] = 768; end
                4: if (k == k_evt) begin
                    sel = $urandom_range(0, 5);
                    case (sel)
                        0: begin px[k] = $urandom_range(box_min(m_player), box_max(m_player)); py[k] = $urandom_range(660, 4095); end
                        1: begin px[k] = ($urandom_range(0, 1) != 0) ? box_min(m_player) : box_max(m_player); py[k] = 660; end
                        2: begin px[k] = ($urandom_range(0, 1) != 0) ? box_min(m_player) - 1 : box_max(m_player) + 1; py[k] = 700; end
                        3: begin px[k] = $urandom_range(1024, 4095); py[k] = $urandom_range(0, 659); end
                        4: begin px[k] = $urandom_range(300, 600); py[k] = $urandom_range(768, 4095); end
                        default: begin px[k] = own_min(m_player) + 50; py[k] = 700; end
                    endcase
                end
                default: ;
            endcase
        end
    endtask

    // Outcome from the game rules: first armed hit/miss, or the timeout cycle.
    task automatic predict(output int kend, output bit was_hit);
        bit h, m;
        kend = MF - 1;
        was_hit = 1'b0;
        for (int k = 0; k < MF; k++) begin
            h = (px[k] >= box_min(m_player)) && (px[k] <= box_max(m_player)) && (py[k] >= 660);
            m = (py[k] >= 768) || (px[k] >= 1024);
            if ((k >= AD && (h || m)) || k == MF - 1) begin
                kend = k;
                was_hit = (k >= AD) && h;
                return;
            end
        end
    endtask

    task automatic run_throw(input int hold, input int mode, input int lock_fire, input int abort_k);
        int          kend, exp_pow;
        bit          was_hit;
        logic [1:0]  nxt_player;
        logic [12:0] obs, exp;
        fill_flight(mode);
        predict(kend, was_hit);
        exp_pow = 1 + (hold - 1) / PT;
        if (exp_pow > 63) exp_pow = 63;

        fire_btn = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            tests++;
            if ({throw_flag, in_throw_flag, end_throw, current_player} !== {3'b000, m_player}) begin
                fails++;
                $display("FAIL charge cyc=%0d flags/player=%b expected=%b", i,
                         {throw_flag, in_throw_flag, end_throw, current_player}, {3'b000, m_player});
            end
        end
        fire_btn = 1'b0;
        step();
        tests++;
        if (throw_flag !== 1'b0) begin
            fails++;
            $display("FAIL early_throw throw_flag=%b expected=0", throw_flag);
        end
        step();
        obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
        exp = {5'b11000, 6'(exp_pow), m_player};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL throw_start hold=%0d got=%b expected=%b", hold, obs, exp);
        end

        for (int k = 0; k < MF; k++) begin
            if (k == abort_k) begin
                start_game = 1'b1;
                step();
                start_game = 1'b0;
                tests++;
                if ({in_throw_flag, current_player} !== {1'b1, m_player}) begin
                    fails++;
                    $display("FAIL start_in_flight got=%b expected=%b", {in_throw_flag, current_player}, {1'b1, m_player});
                end
                rst = 1'b1;
                step();
                rst = 1'b0;
                obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
                tests++;
                if (obs !== 13'd0) begin
                    fails++;
                    $display("FAIL reset_mid_flight got=%b expected=0", obs);
                end
                m_player = 2'b00;
                return;
            end
            xpos_prebuff = 12'(px[k]);
            ypos_prebuff = 12'(py[k]);
            step();
            obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
            exp = {1'b0, k != kend, k == kend, was_hit && k == kend && m_player == 2'b10,
                   was_hit && k == kend && m_player == 2'b01, 6'(exp_pow), m_player};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL flight k=%0d mode=%0d got=%b expected=%b", k, mode, obs, exp);
            end
            if (k == kend) break;
        end

        xpos_prebuff = 12'd0;
        ypos_prebuff = 12'd768;
        nxt_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
        for (int i = 1; i <= SD; i++) begin
            if (i <= SD - 2)
                fire_btn = (lock_fire == 1) ? 1'b1 : (lock_fire == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
            exp = {5'b00000, 6'(exp_pow), (i == SD) ? nxt_player : m_player};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL lockout cyc=%0d got=%b expected=%b", i, obs, exp);
            end
        end
        m_player = nxt_player;

        if (lock_fire == 1) begin
            for (int i = 0; i < 5; i++) step();
        end
        fire_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
            exp = {5'b00000, 6'(exp_pow), m_player};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL no_charge_after_lock cyc=%0d got=%b expected=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        rst = 1'b1; start_game = 1'b0; fire_btn = 1'b0;
        xpos_prebuff = 12'd0; ypos_prebuff = 12'd768;
        repeat (3) step();
        rst = 1'b0;
        obs = {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2, power, current_player};
        tests++;
        if (obs !== 13'd0) begin
            fails++;
            $display("FAIL reset_values got=%b expected=0", obs);
        end
        fire_btn = 1'b1;
        repeat (5) step();
        fire_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({throw_flag, current_player} !== 3'b000) begin
                fails++;
                $display("FAIL idle_fire got=%b expected=000", {throw_flag, current_player});
            end
        end
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        m_player = 2'b01;
        tests++;
        if (current_player !== 2'b01) begin
            fails++;
            $display("FAIL start_game current_player=%b expected=01", current_player);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if ({throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2} !== 5'b0) begin
                fails++;
                $display("FAIL idle_aim flags=%b expected=00000", {throw_flag, in_throw_flag, end_throw, hit_p1, hit_p2});
            end
        end
    endtask

    task automatic test_power_and_hit;
        run_throw(35, 0, 0, -1);
    endtask

    task automatic test_hit_and_miss;
        run_throw(12, 1, 0, -1);
        run_throw(3, 2, 0, -1);
    endtask

    task automatic test_lockout;
        run_throw(20, 2, 1, -1);
        run_throw(25, 4, 2, -1);
    endtask

    task automatic test_timeout_and_saturation;
        run_throw(700, 3, 0, -1);
        run_throw(1, 3, 0, -1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 24; t++)
            run_throw($urandom_range(1, 700), 4, $urandom_range(0, 2), -1);
    endtask

    task automatic test_mid_flight_reset;
        run_throw(40, 3, 0, 5);
    endtask

    initial begin
        test_reset();
        test_power_and_hit();
        test_hit_and_miss();
        test_lockout();
        test_timeout_and_saturation();
        test_random();
        test_mid_flight_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
